hvac_zone_scheduler: RTL

- Shares one heating/cooling plant between NUM_ZONES zones. The plant has a single heater/cooler unit and one damper per zone.
- Each zone has a hysteresis demand detector with the same thresholds as heaterControl: heat below 18, hold 20–22, cool above 22.
- A round-robin scheduler grants the plant to one zone at a time. It enforces a minimum run time, a maximum run quantum, and a dead time between grants.
- Sits above the per-room sensors and drives the plant's heating/cooling enables and the damper selects.

---
 rtl/hvac_pkg.sv | 24 ++
 rtl/hvac_zone_demand.sv | 53 +++++
 rtl/hvac_zone_scheduler.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/hvac_pkg.sv
// Shared types and default thresholds for the zoned HVAC scheduler.
package hvac_pkg;

    // Demand / run-mode code; bit order matches {heating, cooling}.
    typedef enum logic [1:0] {
        DmdNone = 2'b00,
        DmdCool = 2'b01,
        DmdHeat = 2'b10
    } demand_t;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StRun  = 2'b01,
        StDead = 2'b10
    } state_t;

    localparam int unsigned DefHeatStart = 18;
    localparam int unsigned DefSetpoint  = 20;
    localparam int unsigned DefCoolStart = 22;
    localparam int unsigned DefMinRun    = 16;
    localparam int unsigned DefMaxRun    = 64;
    localparam int unsigned DefDeadCyc   = 8;

endpackage

// File: rtl/hvac_zone_demand.sv
// Per-zone hysteresis demand detector with a registered 2-bit demand code.
module hvac_zone_demand import hvac_pkg::*; #(
    parameter int unsigned TEMP_W     = 5,
    parameter int unsigned HEAT_START = DefHeatStart,
    parameter int unsigned SETPOINT   = DefSetpoint,
    parameter int unsigned COOL_START = DefCoolStart
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [TEMP_W-1:0] temp,
    input  logic              en,
    output demand_t           demand
);

    localparam logic [TEMP_W-1:0] HeatStartT = TEMP_W'(HEAT_START);
    localparam logic [TEMP_W-1:0] SetpointT  = TEMP_W'(SETPOINT);
    localparam logic [TEMP_W-1:0] CoolStartT = TEMP_W'(COOL_START);

    demand_t demand_d, demand_q;

    // Next demand: heat/cool only ever leave through NONE, so no direct reversal.
    always_comb begin
        demand_d = demand_q;
        if (!en) begin
            demand_d = DmdNone;
        end else begin
            unique case (demand_q)
                DmdNone: begin
                    if (temp < HeatStartT) begin
                        demand_d = DmdHeat;
                    end else if (temp > CoolStartT) begin
                        demand_d = DmdCool;
                    end
                end
                DmdHeat: if (temp >= SetpointT) demand_d = DmdNone;
                DmdCool: if (temp <= SetpointT) demand_d = DmdNone;
                default: demand_d = DmdNone;
            endcase
        end
    end

    // Demand register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            demand_q <= DmdNone;
        end else begin
            demand_q <= demand_d;
        end
    end

    assign demand = demand_q;

endmodule

// File: rtl/hvac_zone_scheduler.sv
// Round-robin scheduler sharing one heat/cool plant between several zones,
// with minimum run time, run quantum and a dead time between grants.
module hvac_zone_scheduler import hvac_pkg::*; #(
    parameter int unsigned NUM_ZONES  = 4,
    parameter int unsigned TEMP_W     = 5,
    parameter int unsigned HEAT_START = DefHeatStart,
    parameter int unsigned SETPOINT   = DefSetpoint,
    parameter int unsigned COOL_START = DefCoolStart,
    parameter int unsigned MIN_RUN    = DefMinRun,
    parameter int unsigned MAX_RUN    = DefMaxRun,
    parameter int unsigned DEAD_CYC   = DefDeadCyc
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_ZONES*TEMP_W-1:0]  temp,
    input  logic [NUM_ZONES-1:0]         zone_en,
    output logic                         heating,
    output logic                         cooling,
    output logic [NUM_ZONES-1:0]         damper,
    output logic [$clog2(NUM_ZONES)-1:0] active_zone,
    output logic [2*NUM_ZONES-1:0]       demand
);

    localparam int unsigned ZW = $clog2(NUM_ZONES);
    localparam int unsigned RW = (MAX_RUN > 1) ? $clog2(MAX_RUN) : 1;
    localparam int unsigned DW = (DEAD_CYC > 1) ? $clog2(DEAD_CYC) : 1;
    localparam logic [RW-1:0] MinLast  = RW'(MIN_RUN - 1);
    localparam logic [RW-1:0] MaxLast  = RW'(MAX_RUN - 1);
    localparam logic [DW-1:0] DeadLast = DW'(DEAD_CYC - 1);
    localparam logic [ZW-1:0] LastZone = ZW'(NUM_ZONES - 1);

    demand_t dmd [NUM_ZONES];

    for (genvar i = 0; i < NUM_ZONES; i++) begin : g_zone
        hvac_zone_demand #(
            .TEMP_W    (TEMP_W),
            .HEAT_START(HEAT_START),
            .SETPOINT  (SETPOINT),
            .COOL_START(COOL_START)
        ) u_demand (
            .clk   (clk),
            .rst_n (rst_n),
            .temp  (temp[i*TEMP_W +: TEMP_W]),
            .en    (zone_en[i]),
            .demand(dmd[i])
        );
        assign demand[2*i +: 2] = dmd[i];
    end

    state_t               state_d, state_q;
    demand_t              mode_d, mode_q;
    logic [ZW-1:0]        ptr_d, ptr_q;
    logic [ZW-1:0]        zone_d, zone_q;
    logic [RW-1:0]        run_cnt_d, run_cnt_q;
    logic [DW-1:0]        dead_cnt_d, dead_cnt_q;
    logic                 heat_d, heat_q, cool_d, cool_q;
    logic [NUM_ZONES-1:0] damper_d, damper_q;

    logic          pick_valid, others_wait;
    logic [ZW-1:0] pick;
    int unsigned   idx;

    // Round-robin pick starting at the pointer, plus "someone else is waiting".
    always_comb begin
        pick_valid  = 1'b0;
        pick        = '0;
        others_wait = 1'b0;
        idx         = 0;
        for (int unsigned i = 0; i < NUM_ZONES; i++) begin
            idx = 32'(ptr_q) + i;
            if (idx >= NUM_ZONES) idx = idx - NUM_ZONES;
            if (!pick_valid && dmd[ZW'(idx)] != DmdNone) begin
                pick_valid = 1'b1;
                pick       = ZW'(idx);
            end
            if (ZW'(i) != zone_q && dmd[ZW'(i)] != DmdNone) others_wait = 1'b1;
        end
    end

    // FSM next state and registered plant outputs.
    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        ptr_d      = ptr_q;
        zone_d     = zone_q;
        run_cnt_d  = run_cnt_q;
        dead_cnt_d = dead_cnt_q;
        heat_d     = heat_q;
        cool_d     = cool_q;
        damper_d   = damper_q;
        unique case (state_q)
            StIdle: begin
                heat_d   = 1'b0;
                cool_d   = 1'b0;
                damper_d = '0;
                if (pick_valid) begin
                    state_d   = StRun;
                    zone_d    = pick;
                    mode_d    = dmd[pick];
                    run_cnt_d = '0;
                    heat_d    = (dmd[pick] == DmdHeat);
                    cool_d    = (dmd[pick] == DmdCool);
                    damper_d  = NUM_ZONES'(1) << pick;
                    ptr_d     = (pick == LastZone) ? '0 : pick + 1'b1;
                end
            end
            StRun: begin
                // Disable is a safety stop and bypasses the minimum run time.
                if (!zone_en[zone_q] ||
                    (run_cnt_q >= MinLast && dmd[zone_q] != mode_q) ||
                    (run_cnt_q == MaxLast && others_wait)) begin
                    state_d    = StDead;
                    heat_d     = 1'b0;
                    cool_d     = 1'b0;
                    dead_cnt_d = '0;
                end else if (run_cnt_q != MaxLast) begin
                    run_cnt_d = run_cnt_q + 1'b1;
                end
            end
            StDead: begin
                // Damper stays on the last zone while the plant is off.
                heat_d = 1'b0;
                cool_d = 1'b0;
                if (dead_cnt_q == DeadLast) begin
                    state_d  = StIdle;
                    damper_d = '0;
                end else begin
                    dead_cnt_d = dead_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d  = StIdle;
                heat_d   = 1'b0;
                cool_d   = 1'b0;
                damper_d = '0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            mode_q     <= DmdNone;
            ptr_q      <= '0;
            zone_q     <= '0;
            run_cnt_q  <= '0;
            dead_cnt_q <= '0;
            heat_q     <= 1'b0;
            cool_q     <= 1'b0;
            damper_q   <= '0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            ptr_q      <= ptr_d;
            zone_q     <= zone_d;
            run_cnt_q  <= run_cnt_d;
            dead_cnt_q <= dead_cnt_d;
            heat_q     <= heat_d;
            cool_q     <= cool_d;
            damper_q   <= damper_d;
        end
    end

    assign heating     = heat_q;
    assign cooling     = cool_q;
    assign damper      = damper_q;
    assign active_zone = zone_q;

endmodule
